// File: rtl/pmci_spi_egress_responder_if.sv
// SPI pins plus access-event outputs of the PMCI egress SPI responder.
// The master modport is the SPI master / observer side; slave is the responder.
`timescale 1ns/1ps
interface pmci_spi_egress_responder_if #(
    parameter int ADDR_W = 8
);
    logic              spi_sclk;
    logic              spi_csn;
    logic              spi_mosi;
    logic              spi_miso;
    logic              wr_pulse;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              rd_pulse;
    logic [ADDR_W-1:0] rd_addr;
    logic              err_pulse;

    modport master (
        output spi_sclk, spi_csn, spi_mosi,
        input  spi_miso, wr_pulse, wr_addr, wr_data, rd_pulse, rd_addr, err_pulse
    );

    modport slave (
        input  spi_sclk, spi_csn, spi_mosi,
        output spi_miso, wr_pulse, wr_addr, wr_data, rd_pulse, rd_addr, err_pulse
    );
endinterface

// File: rtl/pmci_spi_egress_responder.sv
// Mode-0 SPI slave that oversamples the link in clk, decodes read/write frames
// against a local 32-bit register file and reports each access as a one-cycle event.
//
// state   | meaning
// IDLE    | waiting for csn falling edge
// CMD     | shifting in 8-bit command
// ADDR    | shifting in ADDR_W-bit address
// WDATA   | shifting in 32 write-data bits
// RDATA   | shifting read data out on miso
// DRAIN   | frame finished or rejected; ignore sclk until csn high
`timescale 1ns/1ps
module pmci_spi_egress_responder #(
    parameter int          ADDR_W      = 8,
    parameter int          NUM_REGS    = 16,
    parameter logic [31:0] RD_OOR_DATA = 32'hDEAD_BEEF,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    pmci_spi_egress_responder_if.slave       bus
);

    localparam logic [7:0] CMD_WR    = 8'h02;
    localparam logic [7:0] CMD_RD    = 8'h03;
    localparam int         IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [5:0] ADDR_LAST = 6'(ADDR_W - 1);
    localparam logic [5:0] DATA_LAST = 6'd31;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_WDATA,
        S_RDATA,
        S_DRAIN
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sclk_sync, csn_sync, mosi_sync;
    logic sclk_s, csn_s, mosi_s;
    logic sclk_d, csn_d;
    logic sclk_rise, sclk_fall, csn_rise, csn_fall, sample_en;

    logic [5:0]        cnt;
    logic [31:0]       shift_in;
    logic [31:0]       shift_out;
    logic [31:0]       rx_word;
    logic [ADDR_W-1:0] addr_rx;
    logic [ADDR_W-1:0] addr_q;
    logic              cmd_rd;
    logic              miso_q;
    logic [31:0]       regs [NUM_REGS];
    logic [31:0]       rd_fetch;

    logic cnt_inc, shift_en, shift_out_en, load_rd, addr_ld, cmd_ld, reg_we;
    logic wr_fire, rd_fire, err_fire;

    logic              wr_pulse_q, rd_pulse_q, err_pulse_q;
    logic [ADDR_W-1:0] wr_addr_q, rd_addr_q;
    logic [31:0]       wr_data_q;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < (ADDR_W + 1)'(NUM_REGS);
    endfunction

    // All three pins share the same depth so that their relative timing is preserved.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync <= '0;
            csn_sync  <= '1;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            csn_d     <= 1'b1;
        end else begin
            sclk_sync[0] <= bus.spi_sclk;
            csn_sync[0]  <= bus.spi_csn;
            mosi_sync[0] <= bus.spi_mosi;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sclk_sync[i] <= sclk_sync[i-1];
                csn_sync[i]  <= csn_sync[i-1];
                mosi_sync[i] <= mosi_sync[i-1];
            end
            sclk_d <= sclk_s;
            csn_d  <= csn_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign csn_s     = csn_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign csn_rise  = csn_s & ~csn_d;
    assign csn_fall  = ~csn_s & csn_d;
    // A csn rise forces csn_s high, so a coincident sclk edge is discarded here.
    assign sample_en = sclk_rise & ~csn_s;

    assign rx_word  = {shift_in[30:0], mosi_s};
    assign addr_rx  = rx_word[ADDR_W-1:0];
    assign rd_fetch = in_range(addr_rx) ? regs[addr_rx[IDX_W-1:0]] : RD_OOR_DATA;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        cnt_inc      = 1'b0;
        shift_en     = 1'b0;
        shift_out_en = 1'b0;
        load_rd      = 1'b0;
        addr_ld      = 1'b0;
        cmd_ld       = 1'b0;
        reg_we       = 1'b0;
        wr_fire      = 1'b0;
        rd_fire      = 1'b0;
        err_fire     = 1'b0;
        if (csn_rise) begin
            state_nxt = S_IDLE;
            if (state inside {S_CMD, S_ADDR, S_WDATA, S_RDATA}) err_fire = 1'b1;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (csn_fall) state_nxt = S_CMD;
                end
                S_CMD: begin
                    if (sample_en) begin
                        shift_en = 1'b1;
                        cnt_inc  = 1'b1;
                        if (cnt == 6'd7) begin
                            if (rx_word[7:0] == CMD_WR || rx_word[7:0] == CMD_RD) begin
                                cmd_ld    = 1'b1;
                                state_nxt = S_ADDR;
                            end else begin
                                err_fire  = 1'b1;
                                state_nxt = S_DRAIN;
                            end
                        end
                    end
                end
                S_ADDR: begin
                    if (sample_en) begin
                        shift_en = 1'b1;
                        cnt_inc  = 1'b1;
                        if (cnt == ADDR_LAST) begin
                            addr_ld = 1'b1;
                            if (cmd_rd) begin
                                load_rd   = 1'b1;
                                rd_fire   = 1'b1;
                                state_nxt = S_RDATA;
                            end else begin
                                state_nxt = S_WDATA;
                            end
                        end
                    end
                end
                S_WDATA: begin
                    if (sample_en) begin
                        shift_en = 1'b1;
                        cnt_inc  = 1'b1;
                        if (cnt == DATA_LAST) begin
                            if (in_range(addr_q)) begin
                                reg_we  = 1'b1;
                                wr_fire = 1'b1;
                            end else begin
                                err_fire = 1'b1;
                            end
                            state_nxt = S_DRAIN;
                        end
                    end
                end
                S_RDATA: begin
                    // Stay until the master has sampled bit 0 on the 32nd rise.
                    if (sclk_fall && !csn_s) shift_out_en = 1'b1;
                    if (sample_en) begin
                        cnt_inc = 1'b1;
                        if (cnt == DATA_LAST) state_nxt = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            shift_in    <= '0;
            shift_out   <= '0;
            addr_q      <= '0;
            cmd_rd      <= 1'b0;
            miso_q      <= 1'b0;
            wr_pulse_q  <= 1'b0;
            rd_pulse_q  <= 1'b0;
            err_pulse_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            rd_addr_q   <= '0;
        end else begin
            if (state_nxt != state)           cnt <= '0;
            else if (cnt_inc && cnt != 6'h3F) cnt <= cnt + 6'd1;

            if (shift_en) shift_in <= rx_word;
            if (cmd_ld)   cmd_rd   <= (rx_word[7:0] == CMD_RD);
            if (addr_ld)  addr_q   <= addr_rx;

            if (load_rd)           shift_out <= rd_fetch;
            else if (shift_out_en) shift_out <= {shift_out[30:0], 1'b0};

            if (shift_out_en)            miso_q <= shift_out[31];
            else if (state_nxt != S_RDATA) miso_q <= 1'b0;

            wr_pulse_q  <= wr_fire;
            rd_pulse_q  <= rd_fire;
            err_pulse_q <= err_fire;
            if (wr_fire) begin
                wr_addr_q <= addr_q;
                wr_data_q <= rx_word;
            end
            if (rd_fire) rd_addr_q <= addr_rx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (reg_we) begin
            regs[addr_q[IDX_W-1:0]] <= rx_word;
        end
    end

    assign bus.spi_miso  = (state == S_RDATA) && !csn_s && miso_q;
    assign bus.wr_pulse  = wr_pulse_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.rd_pulse  = rd_pulse_q;
    assign bus.rd_addr   = rd_addr_q;
    assign bus.err_pulse = err_pulse_q;

endmodule

// File: tb/tb_pmci_spi_egress_responder.sv
// Self-checking bench for pmci_spi_egress_responder: drives mode-0 SPI frames and
// compares access events and miso read data against a register-file model.
`timescale 1ns/1ps
module tb_pmci_spi_egress_responder;

    localparam int HALF  = 80;
    localparam int K_WR  = 1;
    localparam int K_RD  = 2;
    localparam int K_ERR = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pmci_spi_egress_responder_if #(.ADDR_W(8)) bus ();

    pmci_spi_egress_responder #(
        .ADDR_W      (8),
        .NUM_REGS    (16),
        .RD_OOR_DATA (32'hDEAD_BEEF),
        .SYNC_STAGES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int          kind;
        logic [7:0]  addr;
        logic [31:0] data;
    } ev_t;

    ev_t         exp_q[$];
    logic [31:0] model [16];
    bit          busy;
    bit          miso_hi;

    task automatic push_ev(input int kind, input logic [7:0] a, input logic [31:0] d);
        ev_t e;
        e.kind = kind;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic spi_xfer(input logic [47:0] tx, input int nbits, input bit keep_cs,
                            output logic [47:0] rx);
        rx = '0;
        bus.spi_csn = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            bus.spi_mosi = tx[47-i];
            #(HALF);
            bus.spi_sclk = 1'b1;
            rx[47-i] = bus.spi_miso;
            #(HALF);
            bus.spi_sclk = 1'b0;
        end
        bus.spi_mosi = 1'b0;
        if (!keep_cs) begin
            #(HALF);
            bus.spi_csn = 1'b1;
        end
    endtask

    task automatic watch_events();
        int          npulse;
        int          kind;
        logic [7:0]  oaddr;
        ev_t         e;
        while (busy) begin
            @(negedge clk);
            if (bus.spi_miso === 1'b1) miso_hi = 1'b1;
            npulse = int'(bus.wr_pulse) + int'(bus.rd_pulse) + int'(bus.err_pulse);
            if (npulse != 0) begin
                kind  = bus.wr_pulse ? K_WR : (bus.rd_pulse ? K_RD : K_ERR);
                oaddr = bus.wr_pulse ? bus.wr_addr : bus.rd_addr;
                checks++;
                if (npulse > 1) begin
                    errors++;
                    $display("FAIL event_multi: %0d pulses in one cycle, required 1 at %0t", npulse, $time);
                end else if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL event_unexpected: kind=%0d addr=%h, required no event at %0t", kind, oaddr, $time);
                end else begin
                    e = exp_q.pop_front();
                    if (kind !== e.kind
                        || (kind == K_WR && (oaddr !== e.addr || bus.wr_data !== e.data))
                        || (kind == K_RD && oaddr !== e.addr)) begin
                        errors++;
                        $display("FAIL event: kind=%0d addr=%h data=%h, required kind=%0d addr=%h data=%h",
                                 kind, oaddr, bus.wr_data, e.kind, e.addr, e.data);
                    end
                end
            end
        end
    endtask

    task automatic run_frame(input logic [47:0] tx, input int nbits, input bit keep_cs,
                             output logic [47:0] rx);
        logic [47:0] r;
        busy    = 1'b1;
        miso_hi = 1'b0;
        r       = '0;
        fork
            begin
                @(negedge clk);
                spi_xfer(tx, nbits, keep_cs, r);
                repeat (20) @(negedge clk);
                busy = 1'b0;
            end
            watch_events();
        join
        rx = r;
    endtask

    task automatic apply_reset();
        rst          = 1'b1;
        bus.spi_csn  = 1'b1;
        bus.spi_sclk = 1'b0;
        bus.spi_mosi = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = '0;
        exp_q.delete();
        repeat (5) @(negedge clk);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [31:0] d, input int nbits);
        logic [47:0] rx;
        if (nbits < 48)   push_ev(K_ERR, 8'h00, 32'h0);
        else if (a < 16) begin
            push_ev(K_WR, a, d);
            model[a[3:0]] = d;
        end else          push_ev(K_ERR, 8'h00, 32'h0);
        run_frame({8'h02, a, d}, nbits, 1'b0, rx);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL write_events_missing: addr=%h %0d events outstanding, required 0", a, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic do_read(input logic [7:0] a);
        logic [47:0] rx;
        logic [31:0] exp_d;
        exp_d = (a < 16) ? model[a[3:0]] : 32'hDEAD_BEEF;
        push_ev(K_RD, a, 32'h0);
        run_frame({8'h03, a, 32'h0}, 48, 1'b0, rx);
        checks++;
        if (rx[31:0] !== exp_d) begin
            errors++;
            $display("FAIL read_data: addr=%h miso=%h, required %h", a, rx[31:0], exp_d);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL read_events_missing: addr=%h %0d events outstanding, required 0", a, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({bus.wr_pulse, bus.rd_pulse, bus.err_pulse, bus.spi_miso} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_strobes: wr/rd/err/miso=%b, required 0000",
                     {bus.wr_pulse, bus.rd_pulse, bus.err_pulse, bus.spi_miso});
        end
        checks++;
        if ({bus.wr_addr, bus.wr_data, bus.rd_addr} !== 48'h0) begin
            errors++;
            $display("FAIL reset_fields: wr_addr=%h wr_data=%h rd_addr=%h, required 0",
                     bus.wr_addr, bus.wr_data, bus.rd_addr);
        end
    endtask

    task automatic test_read_reset_value();
        do_read(8'h03);
    endtask

    task automatic test_write_read();
        do_write(8'h05, 32'hA5A5_1234, 48);
        do_read(8'h05);
        checks++;
        if (bus.wr_addr !== 8'h05 || bus.wr_data !== 32'hA5A5_1234) begin
            errors++;
            $display("FAIL write_hold: wr_addr=%h wr_data=%h, required 05 a5a51234", bus.wr_addr, bus.wr_data);
        end
    endtask

    task automatic test_out_of_range();
        do_read(8'h20);
        do_write(8'h20, 32'h0BAD_F00D, 48);
        do_read(8'h00);
        do_read(8'h05);
    endtask

    task automatic test_bad_cmd();
        logic [47:0] rx;
        push_ev(K_ERR, 8'h00, 32'h0);
        run_frame({8'h7E, 40'hFF_FFFF_FFFF}, 48, 1'b0, rx);
        checks++;
        if (rx !== 48'h0 || miso_hi) begin
            errors++;
            $display("FAIL bad_cmd_miso: miso=%h seen_high=%0d, required 0", rx, miso_hi);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL bad_cmd_err: %0d events outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_abort();
        logic [31:0] old;
        old = model[5];
        do_write(8'h05, 32'h1111_2222, 8 + 8 + 20);
        model[5] = old;
        do_read(8'h05);
    endtask

    task automatic test_back_to_back();
        logic [7:0]  addrs [6];
        logic [31:0] d;
        addrs = '{8'h00, 8'h0F, 8'h10, 8'h09, 8'h01, 8'hFF};
        for (int i = 0; i < 6; i++) begin
            d = $urandom;
            do_write(addrs[i], d, 48);
        end
        for (int i = 0; i < 6; i++) do_read(addrs[i]);
    endtask

    task automatic test_reset_mid_read();
        logic [47:0] rx;
        logic [31:0] cur;
        cur = 32'hA5A5_1234;
        do_write(8'h05, cur, 48);
        push_ev(K_RD, 8'h05, 32'h0);
        run_frame({8'h03, 8'h05, 32'h0}, 8 + 8 + 10, 1'b1, rx);
        checks++;
        if (rx[31:22] !== cur[31:22] || bus.spi_miso !== cur[21]) begin
            errors++;
            $display("FAIL mid_read_data: bits=%b miso=%b, required %b %b",
                     rx[31:22], bus.spi_miso, cur[31:22], cur[21]);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.spi_miso, bus.wr_pulse, bus.rd_pulse, bus.err_pulse} !== 4'b0000) begin
            errors++;
            $display("FAIL mid_read_reset: miso/wr/rd/err=%b, required 0000",
                     {bus.spi_miso, bus.wr_pulse, bus.rd_pulse, bus.err_pulse});
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL mid_read_event: %0d events outstanding, required 0", exp_q.size());
        end
        apply_reset();
        do_read(8'h05);
        do_write(8'h07, 32'h5A5A_C3C3, 48);
        do_read(8'h07);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.spi_sclk = 1'b0;
        bus.spi_csn  = 1'b1;
        bus.spi_mosi = 1'b0;
        busy         = 1'b0;
        miso_hi      = 1'b0;
        apply_reset();
        test_reset();
        test_read_reset_value();
        test_write_read();
        test_out_of_range();
        test_bad_cmd();
        test_abort();
        test_back_to_back();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pmci_spi_egress_responder.md
Name: pmci_spi_egress_responder

Overview:
- Slave-side SPI responder for the PMCI egress SPI link. It is the endpoint that answers the FPGA's egress SPI master, such as the board BMC stand-in.
- Oversamples SCLK/CSN/MOSI in its own clock, decodes read/write frames and serves a local 32-bit register file.
- Emits single-cycle access events so bench checkers and BMC models can track traffic.
- Used in simulation and as a synthesizable loopback endpoint for SPI_LB builds.

Parameters:
ADDR_W, 8, address field width in bits (frame address bits)
NUM_REGS, 16, number of implemented 32-bit registers (must be ≤ 2**ADDR_W)
RD_OOR_DATA, 32'hDEAD_BEEF, data returned for out-of-range reads
SYNC_STAGES, 2, synchronizer depth on spi_sclk/spi_csn/spi_mosi

Ports:
clk  in  1  responder clock; must be ≥ 8x spi_sclk frequency
rst  in  1  asynchronous, active-high reset
spi_sclk  in  1  SPI clock from master, mode 0 (CPOL=0, CPHA=0)
spi_csn  in  1  active-low chip select
spi_mosi  in  1  master-out data, MSB first
spi_miso  out  1  slave-out data, MSB first
wr_pulse  out  1  one-cycle strobe: register write committed
wr_addr  out  ADDR_W  address of committed write
wr_data  out  32  data of committed write
rd_pulse  out  1  one-cycle strobe: read data fetched
rd_addr  out  ADDR_W  address of read
err_pulse  out  1  one-cycle strobe: bad command, out-of-range write, or abort

Behaviour:
- Interface: one clock (clk); rst is asynchronous and active-high.
- Reset: all outputs 0; FSM=IDLE; bit counter=0; all registers 0.
- Input conditioning:
  - sclk, csn and mosi each pass through SYNC_STAGES flops, so they stay mutually aligned.
  - sclk rise/fall are detected from the last two synchronized samples.
  - Sampling occurs only on a synchronized sclk rise while synchronized csn=0.
- Frame format: 8-bit cmd, then ADDR_W-bit addr, then 32 data bits, all MSB first.
  - cmd 8'h02 = write.
  - cmd 8'h03 = read.
- FSM states: IDLE, CMD, ADDR, WDATA, RDATA, DRAIN.
  - IDLE→CMD: on csn falling; counter cleared.
  - CMD→ADDR: after 8th sampled bit.
    - Any cmd other than 02/03 → DRAIN instead, with err_pulse.
  - ADDR→WDATA (cmd 02) or →RDATA (cmd 03): after ADDR_W-th bit.
  - WDATA: on 32nd bit, commit to reg[addr] if addr<NUM_REGS, and assert wr_pulse/wr_addr/wr_data.
    - Out-of-range address: no write; err_pulse instead.
    - Then → DRAIN.
  - RDATA: after the 32nd bit is shifted out → DRAIN.
  - DRAIN: ignore all sclk activity until csn high.
- csn rising in any state → IDLE next clk. If the state was CMD, ADDR, WDATA or RDATA (frame incomplete), err_pulse fires and no write occurs.
- Read timing:
  - On the sample of the last address bit, the shift register loads reg[addr], or RD_OOR_DATA if addr≥NUM_REGS.
  - rd_pulse fires the cycle after that sample.
  - spi_miso presents bit 31 after the next synchronized sclk fall.
  - Each later fall shifts the next bit out, so the master samples bit 31 on the first rising edge after the address.
- spi_miso = 0 in IDLE, CMD, ADDR, WDATA and DRAIN, and whenever csn=1.
- Event latency: wr_pulse/err_pulse assert exactly 1 clk after the detect cycle of the deciding edge.
  - Total ≈ SYNC_STAGES+2 clk after the pin edge.
  - wr_addr/wr_data/rd_addr hold their values until the next event.
- Same-cycle sclk edge and csn rise: csn wins; the edge is discarded.
- Counter is 6 bits and saturates (no wrap); it is cleared on every state change.

Test Plan:
- Write frame 02, addr 8'h05, data 32'hA5A5_1234 → wr_pulse once, wr_addr=05, wr_data=A5A5_1234; a following read of 05 returns A5A5_1234 on miso.
- Read of addr 8'h03 after reset → miso shifts 32'h0000_0000; rd_pulse once with rd_addr=03; err_pulse never asserts.
- Read of addr 8'h20 (≥ NUM_REGS) → miso returns 32'hDEAD_BEEF; a write to 8'h20 gives err_pulse and no register changes.
- cmd 8'h7E, then 40 further sclk cycles → one err_pulse after the 8th bit; miso stays 0; no wr/rd pulses.
- csn deasserted after 20 write-data bits → err_pulse; a subsequent read of that address returns the old value.
- rst asserted mid-read (bit 10 of data) → miso=0 and FSM IDLE immediately; registers cleared; the next full write/read frame completes correctly.
